// File: rtl/sprite_line_renderer.sv
// Ping-pong line-buffer sprite renderer: rasterises the next visible line while the other bank is shown.
// Optional build macro SPRITE_TRANSPARENCY_EN: ROM pixels equal to KEY_COLOR are not written.
module sprite_line_renderer #(
    parameter int          NUM_SPRITES = 20,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_TOTAL     = 525,
    parameter logic [23:0] BG_COLOR    = 24'h000000,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [24*NUM_SPRITES-1:0] gl_array,
    input  logic [9:0]                VGA_HCOUNT,
    input  logic [9:0]                VGA_VCOUNT,
    output logic [12:0]               rom_addr,
    input  logic [23:0]               rom_data,
    output logic [23:0]               pix_rgb,
    output logic                      render_busy,
    output logic                      overrun
);
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, CHECK, FETCH, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [9:0]                hcount_prev_q, hcount_prev_d;
    logic                      wr_bank_q, wr_bank_d;
    logic [24*NUM_SPRITES-1:0] shadow_q, shadow_d;
    logic [9:0]                target_q, target_d;
    logic [9:0]                clr_addr_q, clr_addr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [3:0]                col_q, col_d;
    logic [3:0]                cur_row_q, cur_row_d;
    logic [4:0]                cur_type_q, cur_type_d;
    logic [9:0]                cur_x_q, cur_x_d;
    logic                      drain_q, drain_d;
    logic [12:0]               rom_addr_q, rom_addr_d;
    logic                      p1_valid_q, p1_valid_d;
    logic [10:0]               p1_addr_q, p1_addr_d;
    logic                      p2_valid_q, p2_valid_d;
    logic [10:0]               p2_addr_q, p2_addr_d;
    logic [23:0]               p2_data_q, p2_data_d;
    logic [23:0]               pix_q, pix_d;
    logic                      overrun_q, overrun_d;

    logic        line_start, key_ok, we, rd_bank, entry_hit;
    logic [9:0]  waddr, entry_row;
    logic [23:0] wdata, entry;
    logic [23:0] line_buf0 [H_ACTIVE];
    logic [23:0] line_buf1 [H_ACTIVE];

    assign line_start  = (hcount_prev_q != 10'd0) && (VGA_HCOUNT == 10'd0);
    assign entry       = shadow_q[idx_q*24 +: 24];
    assign entry_row   = target_q - {1'b0, entry[8:0]};
    assign entry_hit   = (entry[23:19] != 5'd0) && (entry_row < 10'd16);
    // The display side must follow the bank swap on the very edge that swaps it.
    assign rd_bank     = ~wr_bank_d;

`ifdef SPRITE_TRANSPARENCY_EN
    assign key_ok = (p2_data_q != KEY_COLOR);
`else
    assign key_ok = 1'b1;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        hcount_prev_d = VGA_HCOUNT;
        wr_bank_d     = wr_bank_q;
        shadow_d      = shadow_q;
        target_d      = target_q;
        clr_addr_d    = clr_addr_q;
        idx_d         = idx_q;
        col_d         = col_q;
        cur_row_d     = cur_row_q;
        cur_type_d    = cur_type_q;
        cur_x_d       = cur_x_q;
        drain_d       = drain_q;
        rom_addr_d    = rom_addr_q;
        p1_valid_d    = 1'b0;
        p1_addr_d     = p1_addr_q;
        p2_valid_d    = p1_valid_q && !line_start;
        p2_addr_d     = p1_addr_q;
        p2_data_d     = rom_data;
        overrun_d     = overrun_q;
        we            = 1'b0;
        waddr         = p2_addr_q[9:0];
        wdata         = p2_data_q;

        if (p2_valid_q && (p2_addr_q < 11'(H_ACTIVE)) && key_ok && !line_start) begin
            we = 1'b1;
        end

        if (line_start) begin
            wr_bank_d  = ~wr_bank_q;
            shadow_d   = gl_array;
            target_d   = (VGA_VCOUNT >= 10'(V_TOTAL - 1)) ? 10'd0 : VGA_VCOUNT + 10'd1;
            clr_addr_d = 10'd0;
            state_d    = CLEAR;
            if (state_q != IDLE) overrun_d = 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    we    = 1'b1;
                    waddr = clr_addr_q;
                    wdata = BG_COLOR;
                    if (clr_addr_q == 10'(H_ACTIVE - 1)) begin
                        idx_d   = IDX_W'(NUM_SPRITES - 1);
                        state_d = (target_q >= 10'(V_ACTIVE)) ? IDLE : CHECK;
                    end else begin
                        clr_addr_d = clr_addr_q + 10'd1;
                    end
                end
                CHECK: begin
                    if (entry_hit) begin
                        cur_type_d = entry[23:19];
                        cur_x_d    = entry[18:9];
                        cur_row_d  = entry_row[3:0];
                        col_d      = 4'd0;
                        rom_addr_d = {entry[23:19], entry_row[3:0], 4'd0};
                        state_d    = FETCH;
                    end else if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                FETCH: begin
                    p1_valid_d = 1'b1;
                    p1_addr_d  = {1'b0, cur_x_q} + {7'd0, col_q};
                    rom_addr_d = {cur_type_q, cur_row_q, col_q + 4'd1};
                    col_d      = col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        drain_d = 1'b0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_q) begin
                        drain_d = 1'b1;
                    end else if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = CHECK;
                    end
                end
                default: ;
            endcase
        end

        pix_d = 24'd0;
        if (VGA_HCOUNT < 10'(H_ACTIVE)) begin
            pix_d = rd_bank ? line_buf1[VGA_HCOUNT] : line_buf0[VGA_HCOUNT];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            hcount_prev_q <= 10'd0;
            wr_bank_q     <= 1'b0;
            target_q      <= 10'd0;
            clr_addr_q    <= 10'd0;
            idx_q         <= '0;
            col_q         <= 4'd0;
            cur_row_q     <= 4'd0;
            cur_type_q    <= 5'd0;
            cur_x_q       <= 10'd0;
            drain_q       <= 1'b0;
            rom_addr_q    <= 13'd0;
            p1_valid_q    <= 1'b0;
            p1_addr_q     <= 11'd0;
            p2_valid_q    <= 1'b0;
            p2_addr_q     <= 11'd0;
            p2_data_q     <= 24'd0;
            pix_q         <= 24'd0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcount_prev_q <= hcount_prev_d;
            wr_bank_q     <= wr_bank_d;
            target_q      <= target_d;
            clr_addr_q    <= clr_addr_d;
            idx_q         <= idx_d;
            col_q         <= col_d;
            cur_row_q     <= cur_row_d;
            cur_type_q    <= cur_type_d;
            cur_x_q       <= cur_x_d;
            drain_q       <= drain_d;
            rom_addr_q    <= rom_addr_d;
            p1_valid_q    <= p1_valid_d;
            p1_addr_q     <= p1_addr_d;
            p2_valid_q    <= p2_valid_d;
            p2_addr_q     <= p2_addr_d;
            p2_data_q     <= p2_data_d;
            pix_q         <= pix_d;
            overrun_q     <= overrun_d;
        end
    end

    // NOTE: the shadow list and line buffers carry no reset; both are rewritten before any use.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        if (we && !wr_bank_q) line_buf0[waddr] <= wdata;
        if (we &&  wr_bank_q) line_buf1[waddr] <= wdata;
    end

    assign rom_addr    = rom_addr_q;
    assign pix_rgb     = pix_q;
    assign overrun     = overrun_q;
    assign render_busy = (state_q != IDLE) || line_start;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Scoreboard bench for sprite_line_renderer: a line sweeper queues expected pixels, a monitor compares them.
module tb_sprite_line_renderer;
    localparam int NS = 20;
    localparam int HA = 640;
    localparam logic [23:0] BG     = 24'h000000;
    localparam logic [23:0] KEY    = 24'hFF00FF;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] YELLOW = 24'hFFFF00;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [24*NS-1:0]   gl_array;
    logic [9:0]         hc = 10'd0;
    logic [9:0]         vc = 10'd0;
    logic [12:0]        rom_addr;
    logic [23:0]        rom_data = 24'd0;
    logic [23:0]        pix_rgb;
    logic               render_busy;
    logic               overrun;

    typedef struct {int cyc; logic [23:0] exp; int h;} item_t;
    item_t       sbq[$];
    logic [23:0] spr      [NS];
    logic [23:0] rend_spr [NS];
    logic [23:0] disp_spr [NS];
    int          rend_t = 0;
    int          disp_t = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy;

    always #10 clk = ~clk;

    sprite_line_renderer dut (
        .clk(clk), .reset(reset), .gl_array(gl_array),
        .VGA_HCOUNT(hc), .VGA_VCOUNT(vc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_rgb(pix_rgb), .render_busy(render_busy), .overrun(overrun)
    );

    function automatic logic [23:0] rom_pix(input logic [12:0] a);
        case (a[12:8])
            5'd1: return GREEN;
            5'd2: return RED;
            5'd3: return BLUE;
            5'd4: return (a[3:0] == 4'd5) ? KEY : YELLOW;
            default: return 24'h808080;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data <= rom_pix(rom_addr);
        cyc      <= cyc + 1;
    end

    always_comb begin
        gl_array = '0;
        for (int i = 0; i < NS; i++) gl_array[i*24 +: 24] = spr[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pixel for target line t: background, then sprites from index NS-1 down to 0.
    function automatic logic [23:0] exp_pix(input int t, input int h);
        logic [23:0] c, e, p;
        int typ, x, y, row, col;
        if (h >= HA) return 24'd0;
        c = BG;
        if (t >= 480) return c;
        for (int i = NS - 1; i >= 0; i--) begin
            e   = disp_spr[i];
            typ = int'(e[23:19]);
            x   = int'(e[18:9]);
            y   = int'(e[8:0]);
            row = t - y;
            col = h - x;
            if (typ != 0 && row >= 0 && row < 16 && col >= 0 && col < 16) begin
                p = rom_pix({5'(typ), 4'(row), 4'(col)});
`ifdef SPRITE_TRANSPARENCY_EN
                if (p != KEY) c = p;
`else
                c = p;
`endif
            end
        end
        return c;
    endfunction

    task automatic set_spr(input int i, input int t, input int x, input int y);
        spr[i] = {5'(t), 10'(x), 9'(y)};
    endtask

    // One 800-clock line; the line start happens on the first column.
    task automatic do_line(input int v, input bit chk, output int nbusy);
        disp_spr = rend_spr;
        disp_t   = rend_t;
        rend_spr = spr;
        rend_t   = (v + 1) % 525;
        vc       = 10'(v);
        nbusy    = 0;
        for (int h = 0; h < 800; h++) begin
            @(posedge clk); #1;
            hc = 10'(h);
            if (chk) sbq.push_back('{cyc, exp_pix(disp_t, h), h});
            #1;
            if (render_busy) nbusy++;
        end
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk); #3;
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                it = sbq.pop_front();
                check($sformatf("pix_T%0d_h%0d", disp_t, it.h), 32'(pix_rgb), 32'(it.exp));
            end
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            spr[i] = 24'd0; rend_spr[i] = 24'd0; disp_spr[i] = 24'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix", 32'(pix_rgb), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_busy", 32'(render_busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        hc = 10'd799;

        do_line(499, 1'b0, busy);
        check("busy_blank_offscreen", 32'(busy), 32'd641);
        do_line(10, 1'b1, busy);
        check("busy_blank_visible", 32'(busy), 32'd661);

        set_spr(3, 1, 100, 50);
        do_line(48, 1'b1, busy);
        do_line(49, 1'b1, busy);
        check("busy_one_hit", 32'(busy), 32'd679);
        do_line(50, 1'b1, busy);
        do_line(65, 1'b0, busy);
        do_line(66, 1'b1, busy);

        set_spr(0, 2, 200, 100);
        set_spr(1, 3, 200, 100);
        do_line(99, 1'b0, busy);
        do_line(100, 1'b1, busy);

        set_spr(0, 0, 0, 0);
        set_spr(1, 0, 0, 0);
        set_spr(3, 1, 630, 120);
        set_spr(4, 1, 700, 120);
        do_line(119, 1'b0, busy);
        check("busy_two_hits", 32'(busy), 32'd697);
        do_line(120, 1'b1, busy);

        set_spr(3, 0, 0, 0);
        set_spr(4, 0, 0, 0);
        set_spr(0, 4, 300, 200);
        set_spr(1, 2, 300, 200);
        do_line(199, 1'b0, busy);
        do_line(200, 1'b1, busy);

        // Early line start 500 clocks into a line, while CLEAR is still running.
        do_line(250, 1'b0, busy);
        check("no_overrun_yet", 32'(overrun), 32'd0);
        vc = 10'd251;
        for (int h = 0; h < 500; h++) begin
            @(posedge clk); #1;
            hc = 10'(h);
        end
        @(posedge clk); #1;
        hc = 10'd0;
        #1;
        check("early_start_busy", 32'(render_busy), 32'd1);
        @(posedge clk); #1;
        hc = 10'd1;
        #1;
        check("overrun_set", 32'(overrun), 32'd1);
        check("restart_busy", 32'(render_busy), 32'd1);
        for (int h = 2; h < 30; h++) begin
            @(posedge clk); #1;
            hc = 10'(h);
        end
        #1;
        check("overrun_sticky", 32'(overrun), 32'd1);
        reset = 1'b0;
        @(posedge clk); #2;
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_busy", 32'(render_busy), 32'd0);
        check("midrst_pix", 32'(pix_rgb), 32'd0);
        check("midrst_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b1;

        repeat (3) @(posedge clk);
        #4;
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Line-buffer renderer that sits directly upstream of the sprite controller's pixel output. Once per scanline it snapshots the 20-entry sprite list. It then rasterises every sprite that intersects the *next* visible line into one half of a ping-pong line buffer, fetching 16×16 sprite pixels from an external sprite ROM. The other half is read out by horizontal position as the current line's colour. At each line start the halves swap, so the VGA output always reads a completed line.

## Interface
Parameters:
- NUM_SPRITES, 20, sprite list entries.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, total lines per frame.
- BG_COLOR, 24'h000000, colour written by the clear pass.
- KEY_COLOR, 24'hFF00FF, transparent ROM colour.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- gl_array  in  24×NUM_SPRITES  sprite entries, packed as {type[23:19], x[18:9], y[8:0]}; type 0 = empty slot.
- VGA_HCOUNT  in  10  current pixel column.
- VGA_VCOUNT  in  10  current line.
- rom_addr  out  13  sprite ROM address {type[4:0], row[3:0], col[3:0]}.
- rom_data  in  24  sprite ROM pixel, valid 1 clk after rom_addr.
- pix_rgb  out  24  {R,G,B} for the current pixel.
- render_busy  out  1  high while the FSM is not IDLE.
- overrun  out  1  sticky flag: a line start occurred before rendering finished.

## Operation
- Line start = VGA_HCOUNT transitions to 0 (registered edge detect, nonzero→0). At each line start:
  - Toggle bank select `wr_bank`; the display side reads `!wr_bank`.
  - Latch all of gl_array into a shadow array.
  - Set target line T = (VGA_VCOUNT+1) mod V_TOTAL.
  - Enter CLEAR.
- FSM states:
  - IDLE: wait for line start.
  - CLEAR: write BG_COLOR to wr_bank addresses 0..H_ACTIVE-1, one per clk. Then go to CHECK with idx = NUM_SPRITES-1. If T ≥ V_ACTIVE, go to IDLE instead.
  - CHECK (1 clk): compute row = T − y (10-bit). Hit when type≠0 and 0 ≤ row < 16. On a miss: if idx==0 go to IDLE, else decrement idx and stay in CHECK. On a hit: go to FETCH with col=0.
  - FETCH (16 clk): issue rom_addr for col 0..15. A 2-stage pipeline carries the write address x+col and the data valid.
  - DRAIN (2 clk): flush the pipeline, then go to CHECK with the next idx, or to IDLE after idx 0.
- Write rule: write rom_data at address x+col (11-bit sum) only if the sum < H_ACTIVE. Columns off the right edge are dropped; addresses never wrap.
- Priority: sprites render from the highest index down to 0, so lower indices overwrite and entry 0 is on top.
- Display side: pix_rgb is registered from line_buf[!wr_bank][VGA_HCOUNT]. When VGA_HCOUNT ≥ H_ACTIVE, pix_rgb = 0.
- Overrun: a line start while the FSM is not IDLE does three things. It sets overrun, which only reset clears. It aborts the current render, discarding the pipeline. It performs the normal swap and restart.

## Timing
- Reset: FSM=IDLE, wr_bank=0, pix_rgb=0, rom_addr=0, render_busy=0, overrun=0, pipeline valids=0. Line-buffer RAM is not reset; it is cleared by the first line's CLEAR pass.
- Pixel latency: 1 clk from VGA_HCOUNT to pix_rgb.
- ROM fetch: rom_addr is issued in cycle n, rom_data is sampled in n+1, and the RAM write happens in n+2.
- Per-line cost: 1 clk (detect) + 640 (CLEAR) + 1 per missed sprite + 19 per hit sprite (1 CHECK + 16 FETCH + 2 DRAIN). Worst case 1 + 640 + 20×19 = 1021 clk, within the 1600-clk line period.
- Single-ported accesses per bank per clk: the render side writes only wr_bank and the display side reads only !wr_bank, so the two never conflict.
- Reset asserted mid-render: next clk is IDLE with all outputs at reset values.

## Configuration
- SPRITE_TRANSPARENCY_EN:
  - Defined: ROM pixels equal to KEY_COLOR are not written, so lower-priority sprites and the background show through.
  - Undefined: every fetched pixel is written, including KEY_COLOR, and the comparator is omitted.

## Test plan
- Reset then one blank line (all types 0) -> render_busy high for exactly 641 clk; the next line's pix_rgb = BG_COLOR for HCOUNT 0..639 and 0 at 640..799.
- Entry 3 = {type 1, x 100, y 50}, ROM type 1 = solid 24'h00FF00 -> line 50 shows green at x 100..115 and BG_COLOR at 99 and 116. Lines 49 and 66 show no green.
- Entries 0 and 1 at the same x/y with types 2 (red) and 3 (blue) -> overlap pixels are red (entry 0 wins).
- Sprite at x 630 -> pixels 630..639 written, nothing written at address 0..5 (no wrap). Sprite at x 700 -> nothing drawn.
- ROM type 4 with col 5 = KEY_COLOR over the red sprite -> with SPRITE_TRANSPARENCY_EN that pixel shows red; without it, that pixel shows 24'hFF00FF.
- Force a line start 500 clk after the previous one -> overrun=1, FSM restarts CLEAR. Overrun stays 1 until reset goes low, then reads 0.
